// File: rtl/frame_mem_if.sv
// ============================================================================
// Module : frame_mem_if
// Brief  : Access bus between the frame buffer and its clients (capture / filter).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface frame_mem_if #(
    parameter int XW   = 8,
    parameter int YW   = 8,
    parameter int PIXW = 1
);
    logic [XW-1:0]   xAddressIn;
    logic [YW-1:0]   yAddressIn;
    logic [PIXW-1:0] dataIn;
    logic            write;
    logic            read;
    logic            clearReq;
    logic [PIXW-1:0] dataOut;
    logic            dataValid;
    logic            busy;
    logic            addrErr;

    modport master (
        output xAddressIn, yAddressIn, dataIn, write, read, clearReq,
        input  dataOut, dataValid, busy, addrErr
    );

    modport slave (
        input  xAddressIn, yAddressIn, dataIn, write, read, clearReq,
        output dataOut, dataValid, busy, addrErr
    );
endinterface

`default_nettype wire

// File: rtl/frame_mem.sv
// ============================================================================
// Module : frame_mem
// Brief  : (x,y)-addressed single-port pixel frame buffer with clear sequencer.
//          Optional range guard enabled by FRAME_MEM_BOUNDS_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_mem #(
    parameter int              IMWIDTH     = 240,
    parameter int              IMHEIGHT    = 180,
    parameter int              PIXW        = 1,
    parameter int              XW          = 8,
    parameter int              YW          = 8,
    parameter logic [PIXW-1:0] CLEAR_VALUE = '0
) (
    input  wire logic   clk,
    input  wire logic   reset,
    frame_mem_if.slave  bus
);
    localparam int            c_DEPTH = IMWIDTH * IMHEIGHT;
    localparam int            c_ADDRW = $clog2(c_DEPTH);
    localparam int            c_FULLW = XW + YW + 1;
    localparam logic [c_ADDRW-1:0] c_LAST = c_ADDRW'(c_DEPTH - 1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_CLEAR = 1'b1;

    logic [PIXW-1:0]    r_mem [0:c_DEPTH-1];
    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_ADDRW-1:0] r_cnt;
    logic [PIXW-1:0]    r_dout;
    logic               r_valid;
    logic               r_err;

    logic [c_FULLW-1:0] w_flat_full;
    logic [c_ADDRW-1:0] w_addr;
    logic               w_inrange;
    logic               w_we;
    logic [c_ADDRW-1:0] w_waddr;
    logic [PIXW-1:0]    w_wdata;
    logic               w_rd;
    logic               w_rd_oob;
    logic               w_err;

    // Full-width product so large coordinates cannot wrap before truncation.
    assign w_flat_full = c_FULLW'(bus.yAddressIn) * c_FULLW'(IMWIDTH)
                       + c_FULLW'(bus.xAddressIn);
    assign w_addr      = c_ADDRW'(w_flat_full);

`ifdef FRAME_MEM_BOUNDS_CHECK_EN
    localparam logic [XW:0] c_XLIM = (XW+1)'(IMWIDTH);
    localparam logic [YW:0] c_YLIM = (YW+1)'(IMHEIGHT);
    assign w_inrange = ({1'b0, bus.xAddressIn} < c_XLIM) &&
                       ({1'b0, bus.yAddressIn} < c_YLIM);
`else
    assign w_inrange = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_S_CLEAR)
                r_cnt <= r_cnt + c_ADDRW'(1);
            else if (bus.clearReq)
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:  if (bus.clearReq)    w_state_next = c_S_CLEAR;
            c_S_CLEAR: if (r_cnt == c_LAST) w_state_next = c_S_IDLE;
            default:                        w_state_next = c_S_IDLE;
        endcase
    end

    // clearReq wins over any access presented in the same IDLE cycle.
    always_comb begin
        w_we     = 1'b0;
        w_waddr  = w_addr;
        w_wdata  = bus.dataIn;
        w_rd     = 1'b0;
        w_rd_oob = 1'b0;
        w_err    = 1'b0;
        if (r_state == c_S_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_cnt;
            w_wdata = CLEAR_VALUE;
        end else if (!bus.clearReq) begin
            w_we     = bus.write && w_inrange;
            w_rd     = bus.read && !bus.write && w_inrange;
            w_rd_oob = bus.read && !bus.write && !w_inrange;
            w_err    = (bus.read || bus.write) && !w_inrange;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_rd)
                r_dout <= r_mem[w_addr];
            else if (w_rd_oob)
                r_dout <= '0;
            r_valid <= w_rd || w_rd_oob;
            r_err   <= w_err;
        end
    end

    assign bus.dataOut   = r_dout;
    assign bus.dataValid = r_valid;
    assign bus.busy      = (r_state == c_S_CLEAR);
    assign bus.addrErr   = r_err;
endmodule

`default_nettype wire

// File: doc/frame_mem.md
# frame_mem

Parametrised single-port pixel frame buffer addressed by (x, y) coordinates. Stores one image of IMWIDTH × IMHEIGHT pixels of PIXW bits each in block RAM, with a registered read path and an explicit read-valid flag. Adds a hardware frame-clear sequencer and an out-of-range address guard. Sits between the pixel-stream front end and the median filter window logic; the filter reads neighbourhoods from it while the capture side writes new frames.

## Interface
Parameters:
- IMWIDTH, 240, pixels per row
- IMHEIGHT, 180, rows per frame
- PIXW, 1, bits per pixel
- XW, 8, x coordinate width (2^XW ≥ IMWIDTH)
- YW, 8, y coordinate width (2^YW ≥ IMHEIGHT)
- CLEAR_VALUE, 0, pixel value written by the clear sequence (PIXW bits)

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- xAddressIn  in  XW  pixel column
- yAddressIn  in  YW  pixel row
- dataIn  in  PIXW  write pixel
- write  in  1  write strobe
- read  in  1  read strobe
- clearReq  in  1  start frame clear (single-cycle pulse or level; sampled only in IDLE)
- dataOut  out  PIXW  registered read data
- dataValid  out  1  dataOut holds the result of the read issued the previous cycle
- busy  out  1  clear sequence in progress
- addrErr  out  1  previous-cycle access used out-of-range coordinates

## Operation
- Flat address = yAddressIn × IMWIDTH + xAddressIn; width ADDRW = $clog2(IMWIDTH×IMHEIGHT). Product computed at full XW+YW+ width before truncation.
- State machine, two states:
  - IDLE: services accesses. clearReq=1 → CLEAR, clear counter ← 0, busy ← 1. clearReq has priority over write/read in the same cycle; that access is dropped.
  - CLEAR: each cycle writes CLEAR_VALUE to address counter, counter +1. When counter == IMWIDTH×IMHEIGHT−1 is written → IDLE, busy ← 0 next edge. write/read/clearReq ignored; dataValid stays 0.
- In IDLE: write=1 → RAM[addr] ← dataIn. write=1 and read=1 together → write performed, read dropped (dataValid=0).
- read=1, write=0 → dataOut ← RAM[addr] next edge, dataValid=1 for exactly that cycle. dataOut holds last read value otherwise.
- RAM array is not reset; contents after power-up undefined until a clear or writes.

## Timing
- Reset values: dataOut=0, dataValid=0, busy=0, addrErr=0, state=IDLE, counter=0.
- Read latency 1 cycle; back-to-back reads every cycle, full throughput.
- Write takes effect at the strobe edge; read of the same address on the next cycle returns the new value.
- Clear duration exactly IMWIDTH×IMHEIGHT cycles of busy=1 (43200 at defaults); first access accepted on the cycle busy is sampled 0.
- Reset asserted mid-clear: immediate return to IDLE, busy=0; memory partially cleared, no completion guarantee.
- dataValid and addrErr are one-cycle pulses, registered, never combinational from inputs.

## Configuration
- FRAME_MEM_BOUNDS_CHECK_EN defined: access with xAddressIn ≥ IMWIDTH or yAddressIn ≥ IMHEIGHT is rejected—write dropped, read returns dataOut=0 with dataValid=1, addrErr=1 for one cycle.
- Not defined: no range check; flat address truncated to ADDRW and used directly (out-of-range may alias or be unmapped); addrErr tied 0.

## Test plan
- Reset then write (x=5,y=3,data=1), read same address next cycle → dataOut=1, dataValid=1 exactly one cycle after read strobe.
- Write corners (0,0)=1 and (239,179)=1, read both plus (1,0) → 1, 1, 0 (after clear); confirms flat-address arithmetic at 240×180.
- clearReq pulse → busy high for exactly 43200 cycles; reads during busy give dataValid=0; afterwards every sampled address reads CLEAR_VALUE.
- write and read asserted together at (10,10) with data=1 → dataValid=0 that cycle's result; subsequent read returns 1.
- With FRAME_MEM_BOUNDS_CHECK_EN: write (240,0)=1 then read (240,0) → addrErr=1, dataOut=0, and (0,1) unchanged (no alias corruption).
- Assert reset at clear cycle 1000 → busy=0, dataOut=0, dataValid=0 immediately; new clearReq after release runs full 43200 cycles.
